// File: rtl/cell_write_arbiter.sv
// Arbitrates edit/search cell writes onto the memory_controller write port
// and runs a full-screen clear sweep that also resets every highlight bit.
module cell_write_arbiter #(
  parameter int         COLS_S     = 80,
  parameter int         ROWS_S     = 60,
  parameter int         COLS_L     = 40,
  parameter int         ROWS_L     = 30,
  parameter logic [6:0] CLR_ASCII  = 7'h20,
  parameter logic [5:0] CLR_COLOUR = 6'b111111
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       sL,
  input  logic       clear_req,
  output logic       clear_busy,
  input  logic       r0_req,
  input  logic [6:0] r0_x,
  input  logic [5:0] r0_y,
  input  logic [6:0] r0_ascii,
  input  logic [5:0] r0_colour,
  output logic       r0_ack,
  input  logic       r1_req,
  input  logic [6:0] r1_x,
  input  logic [5:0] r1_y,
  input  logic [6:0] r1_ascii,
  input  logic [5:0] r1_colour,
  output logic       r1_ack,
  output logic [6:0] wrx,
  output logic [5:0] wry,
  output logic [6:0] wascii,
  output logic [5:0] wcolour,
  output logic       wren,
  output logic [6:0] hix,
  output logic [5:0] hiy,
  output logic       highlight,
  output logic       hien,
  output logic [7:0] drop_cnt
);

  localparam logic [7:0] COLS_S_B = 8'(COLS_S);
  localparam logic [7:0] ROWS_S_B = 8'(ROWS_S);
  localparam logic [7:0] COLS_L_B = 8'(COLS_L);
  localparam logic [7:0] ROWS_L_B = 8'(ROWS_L);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t     state_reg, state_next;
  logic       rr_last_reg, rr_last_next;
  logic       sl_snap_reg, sl_snap_next;
  logic [6:0] cx_reg, cx_next;
  logic [5:0] cy_reg, cy_next;

  logic [6:0] wrx_next, wascii_next, hix_next;
  logic [5:0] wry_next, wcolour_next, hiy_next;
  logic       wren_next, hien_next, highlight_next;
  logic       r0_ack_next, r1_ack_next, clear_busy_next;
  logic [7:0] drop_cnt_next;

  // A requester whose ack is high this cycle is still showing the data
  // just written, so it sits out one cycle.
  logic [1:0] req_vec, ack_vec, elig;
  assign req_vec = {r1_req, r0_req};
  assign ack_vec = {r1_ack, r0_ack};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
      assign elig[gi] = req_vec[gi] & ~ack_vec[gi];
    end
  endgenerate

  logic grant0, grant1;
  assign grant0 = elig[0] & (~elig[1] | rr_last_reg);
  assign grant1 = elig[1] & (~elig[0] | ~rr_last_reg);

  logic [6:0] g_x, g_ascii;
  logic [5:0] g_y, g_colour;
  assign g_x      = grant1 ? r1_x      : r0_x;
  assign g_y      = grant1 ? r1_y      : r0_y;
  assign g_ascii  = grant1 ? r1_ascii  : r0_ascii;
  assign g_colour = grant1 ? r1_colour : r0_colour;

  logic [7:0] cols_cur, rows_cur, clr_cols, clr_rows;
  assign cols_cur = sL ? COLS_L_B : COLS_S_B;
  assign rows_cur = sL ? ROWS_L_B : ROWS_S_B;
  assign clr_cols = sl_snap_reg ? COLS_L_B : COLS_S_B;
  assign clr_rows = sl_snap_reg ? ROWS_L_B : ROWS_S_B;

  logic in_range, last_col, last_row;
  assign in_range = ({1'b0, g_x} < cols_cur) && ({2'b00, g_y} < rows_cur);
  assign last_col = ({1'b0, cx_reg} == clr_cols - 8'd1);
  assign last_row = ({2'b00, cy_reg} == clr_rows - 8'd1);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= ARB;
      rr_last_reg <= 1'b1;
      sl_snap_reg <= 1'b0;
      cx_reg      <= '0;
      cy_reg      <= '0;
      wrx         <= '0;
      wry         <= '0;
      wascii      <= '0;
      wcolour     <= '0;
      wren        <= 1'b0;
      hix         <= '0;
      hiy         <= '0;
      highlight   <= 1'b0;
      hien        <= 1'b0;
      r0_ack      <= 1'b0;
      r1_ack      <= 1'b0;
      clear_busy  <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      state_reg   <= state_next;
      rr_last_reg <= rr_last_next;
      sl_snap_reg <= sl_snap_next;
      cx_reg      <= cx_next;
      cy_reg      <= cy_next;
      wrx         <= wrx_next;
      wry         <= wry_next;
      wascii      <= wascii_next;
      wcolour     <= wcolour_next;
      wren        <= wren_next;
      hix         <= hix_next;
      hiy         <= hiy_next;
      highlight   <= highlight_next;
      hien        <= hien_next;
      r0_ack      <= r0_ack_next;
      r1_ack      <= r1_ack_next;
      clear_busy  <= clear_busy_next;
      drop_cnt    <= drop_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rr_last_next    = rr_last_reg;
    sl_snap_next    = sl_snap_reg;
    cx_next         = cx_reg;
    cy_next         = cy_reg;
    wrx_next        = wrx;
    wry_next        = wry;
    wascii_next     = wascii;
    wcolour_next    = wcolour;
    wren_next       = 1'b0;
    hix_next        = hix;
    hiy_next        = hiy;
    highlight_next  = highlight;
    hien_next       = 1'b0;
    r0_ack_next     = 1'b0;
    r1_ack_next     = 1'b0;
    clear_busy_next = 1'b0;
    drop_cnt_next   = drop_cnt;

    case (state_reg)
      ARB: begin
        if (clear_req) begin
          state_next   = CLEAR;
          sl_snap_next = sL;
          cx_next      = '0;
          cy_next      = '0;
        end else if (grant0 || grant1) begin
          wrx_next     = g_x;
          wry_next     = g_y;
          wascii_next  = g_ascii;
          wcolour_next = g_colour;
          wren_next    = in_range;
          r0_ack_next  = grant0;
          r1_ack_next  = grant1;
          rr_last_next = grant1;
          if (!in_range && drop_cnt != 8'hFF)
            drop_cnt_next = drop_cnt + 8'd1;
        end
      end
      CLEAR: begin
        wrx_next        = cx_reg;
        wry_next        = cy_reg;
        wascii_next     = CLR_ASCII;
        wcolour_next    = CLR_COLOUR;
        wren_next       = 1'b1;
        hix_next        = cx_reg;
        hiy_next        = cy_reg;
        highlight_next  = 1'b0;
        hien_next       = 1'b1;
        clear_busy_next = 1'b1;
        // Row-major sweep; leaving on the last cell lets ARB arbitrate
        // in the same cycle that cell is presented.
        if (last_col) begin
          cx_next = '0;
          if (last_row) state_next = ARB;
          else          cy_next    = cy_reg + 6'd1;
        end else begin
          cx_next = cx_reg + 7'd1;
        end
      end
      default: state_next = ARB;
    endcase
  end

endmodule

// File: tb/tb_cell_write_arbiter.sv
// Randomised and directed stimulus for cell_write_arbiter, checked every
// cycle against a cycle-level behavioural model of arbitration and clear.
module tb_cell_write_arbiter;
  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       sL = 1'b0;
  logic       clear_req = 1'b0;
  logic       r0_req = 1'b0, r1_req = 1'b0;
  logic [6:0] r0_x = '0, r1_x = '0, r0_ascii = '0, r1_ascii = '0;
  logic [5:0] r0_y = '0, r1_y = '0, r0_colour = '0, r1_colour = '0;
  logic       clear_busy, r0_ack, r1_ack, wren, highlight, hien;
  logic [6:0] wrx, wascii, hix;
  logic [5:0] wry, wcolour, hiy;
  logic [7:0] drop_cnt;

  cell_write_arbiter dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .sL(sL), .clear_req(clear_req),
    .clear_busy(clear_busy),
    .r0_req(r0_req), .r0_x(r0_x), .r0_y(r0_y), .r0_ascii(r0_ascii),
    .r0_colour(r0_colour), .r0_ack(r0_ack),
    .r1_req(r1_req), .r1_x(r1_x), .r1_y(r1_y), .r1_ascii(r1_ascii),
    .r1_colour(r1_colour), .r1_ack(r1_ack),
    .wrx(wrx), .wry(wry), .wascii(wascii), .wcolour(wcolour), .wren(wren),
    .hix(hix), .hiy(hiy), .highlight(highlight), .hien(hien),
    .drop_cnt(drop_cnt)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected outputs for the current cycle plus sweep state.
  logic [6:0] e_wrx, e_wascii, e_hix;
  logic [5:0] e_wry, e_wcolour, e_hiy;
  logic       e_wren, e_hien, e_hl, e_ack0, e_ack1, e_busy;
  int         e_drop;
  int         m_left, m_idx, m_cols, m_last;

  task automatic model_reset();
    e_wrx = '0; e_wry = '0; e_wascii = '0; e_wcolour = '0; e_wren = 0;
    e_hix = '0; e_hiy = '0; e_hl = 0; e_hien = 0;
    e_ack0 = 0; e_ack1 = 0; e_busy = 0; e_drop = 0;
    m_left = 0; m_idx = 0; m_cols = 80; m_last = 1;
  endtask

  task automatic model_step();
    bit el0, el1;
    int g, cols, rows;
    if (!resetn) begin
      model_reset();
      return;
    end
    el0 = r0_req && !e_ack0;
    el1 = r1_req && !e_ack1;
    e_ack0 = 0; e_ack1 = 0; e_wren = 0; e_hien = 0; e_busy = 0;
    if (m_left > 0) begin
      e_wrx = 7'(m_idx % m_cols);
      e_wry = 6'(m_idx / m_cols);
      e_wascii = 7'h20; e_wcolour = 6'h3F; e_wren = 1;
      e_hix = e_wrx; e_hiy = e_wry; e_hl = 0; e_hien = 1; e_busy = 1;
      m_idx++;
      m_left--;
    end else if (clear_req) begin
      m_cols = sL ? 40 : 80;
      m_left = sL ? 40 * 30 : 80 * 60;
      m_idx  = 0;
      $display("txn clear cols=%0d cells=%0d t=%0t", m_cols, m_left, $time);
    end else if (el0 || el1) begin
      if (el0 && el1) g = 1 - m_last;
      else            g = el0 ? 0 : 1;
      cols = sL ? 40 : 80;
      rows = sL ? 30 : 60;
      e_wrx     = g ? r1_x : r0_x;
      e_wry     = g ? r1_y : r0_y;
      e_wascii  = g ? r1_ascii : r0_ascii;
      e_wcolour = g ? r1_colour : r0_colour;
      e_wren    = (int'(e_wrx) < cols) && (int'(e_wry) < rows);
      if (!e_wren && e_drop < 255) e_drop++;
      e_ack0 = (g == 0);
      e_ack1 = (g == 1);
      m_last = g;
      $display("txn r%0d x=%0d y=%0d ascii=%02h colour=%02h wren=%0d drop=%0d",
               g, e_wrx, e_wry, e_wascii, e_wcolour, e_wren, e_drop);
    end
  endtask

  task automatic check_outputs();
    check_val("wrx", wrx, e_wrx);
    check_val("wry", wry, e_wry);
    check_val("wascii", wascii, e_wascii);
    check_val("wcolour", wcolour, e_wcolour);
    check_val("wren", wren, e_wren);
    check_val("hix", hix, e_hix);
    check_val("hiy", hiy, e_hiy);
    check_val("highlight", highlight, e_hl);
    check_val("hien", hien, e_hien);
    check_val("r0_ack", r0_ack, e_ack0);
    check_val("r1_ack", r1_ack, e_ack1);
    check_val("clear_busy", clear_busy, e_busy);
    check_val("drop_cnt", drop_cnt, e_drop);
    check_val("one_ack", r0_ack & r1_ack, 0);
  endtask

  // Inputs are already driven; advance one clock and compare.
  task automatic cycle();
    model_step();
    @(posedge CLOCK_50);
    #1;
    check_outputs();
  endtask

  task automatic new_r0(input int xmax);
    r0_x = 7'($urandom_range(0, xmax)); r0_y = 6'($urandom_range(0, 63));
    r0_ascii = 7'($urandom); r0_colour = 6'($urandom);
  endtask

  task automatic new_r1(input int xmax);
    r1_x = 7'($urandom_range(0, xmax)); r1_y = 6'($urandom_range(0, 63));
    r1_ascii = 7'($urandom); r1_colour = 6'($urandom);
  endtask

  initial begin
    int busy_n, acks, done;
    logic [6:0] fx, lx;
    logic [5:0] fy, ly;
    model_reset();

    // Reset state
    repeat (3) cycle();
    resetn = 1'b1;
    cycle();

    // Single write, one-cycle latency, ack for one cycle
    r0_req = 1; r0_x = 5; r0_y = 3; r0_ascii = 7'h41; r0_colour = 6'h0F;
    cycle();
    check_val("t1_wren", wren, 1);
    check_val("t1_wrx", wrx, 5);
    check_val("t1_ascii", wascii, 7'h41);
    check_val("t1_ack", r0_ack, 1);
    r0_req = 0;
    cycle();
    check_val("t1_wren_off", wren, 0);
    check_val("t1_ack_off", r0_ack, 0);

    // Both requesters: alternate grants, one write every cycle
    r0_req = 1; r1_req = 1;
    r0_x = 7'd10; r0_y = 6'd2; r1_x = 7'd20; r1_y = 6'd4;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check_val("t2_wren", wren, 1);
      check_val("t2_alt", r0_ack ^ r1_ack, 1);
      if (e_ack0) begin r0_x = 7'($urandom_range(0, 79)); r0_y = 6'($urandom_range(0, 59)); r0_ascii = 7'($urandom); end
      if (e_ack1) begin r1_x = 7'($urandom_range(0, 79)); r1_y = 6'($urandom_range(0, 59)); r1_ascii = 7'($urandom); end
    end
    r0_req = 0; r1_req = 0;
    cycle();

    // Out-of-range drops in large mode, saturating at 255
    sL = 1; r1_req = 1; r1_x = 7'd45; r1_y = 6'd10;
    acks = 0;
    for (int i = 0; i < 700 && acks < 300; i++) begin
      cycle();
      if (e_ack1) begin
        acks++;
        if (acks == 1) begin
          check_val("t3_wren", wren, 0);
          check_val("t3_drop1", drop_cnt, 1);
        end
      end
    end
    r1_req = 0;
    cycle();
    check_val("t3_acks", acks, 300);
    check_val("t3_drop_sat", drop_cnt, 255);

    // Small-mode clear sweep
    sL = 0; clear_req = 1;
    cycle();
    clear_req = 0;
    busy_n = 0; fx = '1; fy = '1; lx = '0; ly = '0;
    for (int i = 0; i < 4805; i++) begin
      cycle();
      if (clear_busy) begin
        if (busy_n == 0) begin fx = wrx; fy = wry; end
        lx = wrx; ly = wry;
        busy_n++;
      end
    end
    check_val("t4_busy_len", busy_n, 4800);
    check_val("t4_first", {fx, fy}, {7'd0, 6'd0});
    check_val("t4_last", {lx, ly}, {7'd79, 6'd59});

    // Held request during a clear with sL toggling
    clear_req = 1;
    cycle();
    clear_req = 0;
    r0_req = 1; r0_x = 7'd60; r0_y = 6'd20; r0_ascii = 7'h42;
    done = 0;
    for (int i = 0; i < 5000; i++) begin
      if (i % 37 == 0) sL = ~sL;
      if (i == 4700) sL = 0;
      cycle();
      if (clear_busy) check_val("t5_no_ack", r0_ack, 0);
      else if (i > 0) begin done = 1; break; end
    end
    check_val("t5_sweep_end", done, 1);
    check_val("t5_ack_first_arb", r0_ack, 1);
    r0_req = 0;
    cycle();

    // Asynchronous reset in the middle of a sweep
    clear_req = 1;
    cycle();
    clear_req = 0;
    for (int i = 0; i < 2000 && m_idx < 1000; i++) cycle();
    resetn = 0;
    #2;
    check_val("t6_async_wren", wren, 0);
    check_val("t6_async_busy", clear_busy, 0);
    check_val("t6_async_hien", hien, 0);
    check_val("t6_async_wrx", wrx, 0);
    cycle();
    resetn = 1;
    r1_req = 1; r1_x = 7'd7; r1_y = 6'd8; r1_ascii = 7'h43; r1_colour = 6'h01;
    cycle();
    check_val("t6_r1_ack", r1_ack, 1);
    r1_req = 0;
    cycle();

    // Randomised traffic with occasional clears in either mode
    for (int i = 0; i < 4000; i++) begin
      clear_req = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 49) == 0) sL = ~sL;
      if (e_ack0) begin
        if ($urandom_range(0, 1)) new_r0(84); else r0_req = 0;
      end else if (!r0_req && $urandom_range(0, 2) == 0) begin
        r0_req = 1; new_r0(84);
      end
      if (e_ack1) begin
        if ($urandom_range(0, 1)) new_r1(84); else r1_req = 0;
      end else if (!r1_req && $urandom_range(0, 2) == 0) begin
        r1_req = 1; new_r1(84);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cell_write_arbiter.md
Name: cell_write_arbiter

Overview:
- Sits between the text requesters (edit_mode, search_mode) and the memory_controller write and highlight ports.
- Replaces the static SW[1] mux with a request/acknowledge arbiter, so both modes can write without corrupting each other.
- Adds a built-in screen-clear sequencer that sweeps every character cell.
- All outputs are registered; one memory write per cycle at most.

Parameters:
- COLS_S, 80, columns in small-character mode (sL=0)
- ROWS_S, 60, rows in small-character mode
- COLS_L, 40, columns in large-character mode (sL=1)
- ROWS_L, 30, rows in large-character mode
- CLR_ASCII, 7'h20, character written by clear
- CLR_COLOUR, 6'b111111, colour written by clear

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- sL  in  1  large-mode select; determines grid bounds
- clear_req  in  1  level; request full-screen clear
- clear_busy  out  1  clear sweep in progress
- r0_req  in  1  edit requester write request
- r0_x  in  7  column
- r0_y  in  6  row
- r0_ascii  in  7  character
- r0_colour  in  6  colour
- r0_ack  out  1  one-cycle acknowledge
- r1_req, r1_x, r1_y, r1_ascii, r1_colour, r1_ack  same as r0_*, for the search requester
- wrx  out  7  memory write column
- wry  out  6  memory write row
- wascii  out  7  memory write character
- wcolour  out  6  memory write colour
- wren  out  1  memory write strobe, one cycle per write
- hix  out  7  highlight port column
- hiy  out  6  highlight port row
- highlight  out  1  highlight value
- hien  out  1  highlight write strobe
- drop_cnt  out  8  saturating count of out-of-range requests

Behaviour:
Reset and clocking:
- Clock is CLOCK_50; reset is resetn, asynchronous, active-low.
- On reset, all outputs are 0 (wrx, wry, wascii, wcolour, wren, hix, hiy, highlight, hien, r0_ack, r1_ack, clear_busy, drop_cnt).
- On reset, state=ARB and rr_last=1, so r0 wins the first tie.

States:
- ARB: normal arbitration.
- CLEAR: clear sweep.

ARB, per cycle:
- A requester is eligible iff its req=1 and its ack is 0 this cycle. This blocks a double write of held data.
- Priority: clear_req beats all requesters.
- If clear_req=1, next state=CLEAR. No write is issued this cycle and no ack is given.
- Else if exactly one requester is eligible, it is granted.
- Else if both are eligible, the one not equal to rr_last is granted.
- On a grant, at the next edge:
  - w* outputs load that requester's fields.
  - The requester's ack=1 for exactly one cycle.
  - rr_last is set to the granted requester.
  - wren=1, unless the coordinate is out of range for the current sL (x>=COLS or y>=ROWS).
  - If out of range: wren=0, ack still 1, and drop_cnt increments, saturating at 255.
- Latency from req sampled to wren/ack is 1 cycle.
- A requester must present new data or drop req in the cycle its ack is high.
- Sustained aggregate throughput is 1 write/cycle when both requesters alternate; a single requester gets 1 write per 2 cycles.
- wren, ack and hien default to 0 in any cycle without a write.

CLEAR:
- Snapshot sL on entry; later sL changes do not affect an active sweep.
- Sweep is row-major: x=0..COLS-1 inner, y=0..ROWS-1 outer, one cell per cycle.
- For every cell, set together: wren=1, wascii=CLR_ASCII, wcolour=CLR_COLOUR, hien=1, highlight=0, hix=wrx, hiy=wry.
- clear_busy=1 from the first sweep cycle through the last cell cycle inclusive, then returns to 0.
- Duration is COLS*ROWS cycles: 4800 small, 1200 large.
- No acks are issued during CLEAR; requests stay pending and are serviced in ARB afterwards.
- clear_req during CLEAR is ignored.
- If clear_req is still high after the sweep, a new sweep starts. Requesters are expected to pulse it.
- The next state after the last cell is ARB.

Other rules:
- hien is only ever asserted by CLEAR; there is no requester path to the highlight port.
- sL change while in ARB takes effect on the bounds check of the next grant.
- A reset mid-CLEAR aborts immediately: the partial sweep is left in memory and all outputs go to 0.

Test Plan:
1. Reset, then r0_req=1 with r0 = (x=5, y=3, 'A'=7'h41, colour 6'h0F) held 1 cycle → next cycle wren=1, wrx=5, wry=3, wascii=7'h41, wcolour=6'h0F, r0_ack=1. The following cycle wren=0 and r0_ack=0.
2. r0_req and r1_req both held high with distinct data for 6 cycles, fresh data each ack → grants alternate r0, r1, r0, r1… with wren=1 every cycle. Never two acks in the same cycle.
3. sL=1, r1 writes x=45, y=10 → r1_ack=1, wren=0, drop_cnt=1. Repeat 300 times → drop_cnt=255.
4. sL=0, pulse clear_req → clear_busy high for exactly 4800 cycles. First write is (0,0), the last is (79,59). Every write has wascii=7'h20, hien=1, highlight=0.
5. During a clear, hold r0_req=1 and toggle sL → no r0_ack until clear_busy falls. Bounds stay 80×60. r0 is granted on the first ARB cycle after the sweep.
6. Deassert resetn during a clear at cell 1000 → all outputs 0 asynchronously. After release, state=ARB and a new r1 request is acked in 1 cycle.
